// File: rtl/des_pkg.sv
// DES substitution constants, P permutation and the FSM state type
// shared by the sequential S-box engine.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Entry [box][row*16 + col]; box 0 is S1.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    // Output bit i (1-based, MSB = 1) takes input bit P_TABLE[i-1].
    localparam int unsigned P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Row is the outer bit pair {b5,b0}, column the inner four bits.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] idx, input logic [5:0] chunk);
        return SBOX[idx][{chunk[5], chunk[0], chunk[4:1]}];
    endfunction

    function automatic logic [31:0] p_permute(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            y[5'(31 - i)] = x[5'(32 - P_TABLE[i])];
        end
        return y;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One DES S-box lane: selects the box by index and returns its 4-bit value.
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0] idx,
    input  logic [5:0] chunk,
    output logic [3:0] value
);

    // Pure table lookup, no state.
    always_comb begin
        value = sbox_lookup(idx, chunk);
    end

endmodule

// File: rtl/des_sbox_engine.sv
// Sequential DES f-function substitution stage: LANES S-boxes per cycle,
// optional P permutation, valid/ready on both sides.
module des_sbox_engine
    import des_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int APPLY_P = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_illegal
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    localparam int            GROUPS = 8 / LANES;
    localparam int            CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST   = CW'(GROUPS - 1);

    state_t         state, state_n;
    logic [CW-1:0]  grp;
    logic [47:0]    din_q;
    logic [3:0]     res_q [8];
    logic [5:0]     chunks [8];
    logic [2:0]     lane_box [LANES];
    logic [5:0]     lane_chunk [LANES];
    logic [3:0]     lane_val [LANES];
    logic [31:0]    raw;
    logic [31:0]    shaped;
    logic           accept;

    assign accept = in_valid & in_ready;

    // Split the captured half-block into its eight 6-bit chunks, S1 first.
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            chunks[k] = din_q[6*(7-k) +: 6];
        end
    end

    // Lane l of group g handles S-box g*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_box[l]   = 3'(int'(grp) * LANES + l);
        assign lane_chunk[l] = chunks[lane_box[l]];

        des_sbox_lut u_lut (
            .idx   (lane_box[l]),
            .chunk (lane_chunk[l]),
            .value (lane_val[l])
        );
    end

    // Reassemble the result nibbles, S1 in the top nibble.
    always_comb begin
        raw = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            raw[4*(7-k) +: 4] = res_q[k];
        end
    end

    if (APPLY_P != 0) begin : g_perm
        assign shaped = p_permute(raw);
    end else begin : g_noperm
        assign shaped = raw;
    end

    assign out_data = out_valid ? shaped : '0;

    // Next-state and handshake outputs; DONE can hand straight back to BUSY.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (grp == LAST) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_n = in_valid ? BUSY : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, capture on accept, and per-cycle S-box group evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grp   <= '0;
            din_q <= '0;
            for (int unsigned k = 0; k < 8; k++) res_q[k] <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                din_q <= in_data;
                grp   <= '0;
                for (int unsigned k = 0; k < 8; k++) res_q[k] <= '0;
            end else if (state == BUSY) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    res_q[lane_box[l]] <= lane_val[l];
                end
                grp <= (grp == LAST) ? '0 : grp + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Scoreboard bench for des_sbox_engine: four instances covering LANES 8/1/2/4
// with and without P, directed known answers plus randomized traffic.
module tb_des_sbox_engine;

    localparam int NI = 4;
    localparam int LN [NI] = '{8, 1, 2, 4};
    localparam int AP [NI] = '{0, 0, 1, 1};

    localparam int unsigned SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };
    localparam int unsigned PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                        2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

    logic              clk = 1'b0;
    logic [NI-1:0]     rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [47:0]       in_data [NI];
    logic [31:0]       out_data [NI];

    int unsigned n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {
        int unsigned inst;
        logic [31:0] data;
        int unsigned acc;
    } exp_t;
    exp_t sb [$];

    bit          presenting [NI];
    logic [31:0] cur_exp [NI];
    int unsigned bcnt [NI];
    bit          rand_rdy [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        des_sbox_engine #(.LANES(LN[g]), .APPLY_P(AP[g])) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // DES S-layer computed chunk by chunk with arithmetic, then P if requested.
    function automatic logic [31:0] ref_f(input logic [47:0] d, input int ap);
        int unsigned raw, res, ch, row, col;
        raw = 0;
        res = 0;
        for (int b = 0; b < 8; b++) begin
            ch  = 32'(d >> (42 - 6 * b)) & 63;
            row = ((ch >> 5) << 1) | (ch & 1);
            col = (ch >> 1) & 15;
            raw = (raw << 4) | SB[b][row * 16 + col];
        end
        if (ap == 0) return raw;
        for (int i = 0; i < 32; i++) res = (res << 1) | ((raw >> (32 - PT[i])) & 1);
        return res;
    endfunction

    function automatic int find_entry(input int unsigned k);
        for (int i = 0; i < sb.size(); i++) if (sb[i].inst == k) return i;
        return -1;
    endfunction

    // Monitor: latency, data, hold stability, busy length, zero output when idle.
    always @(negedge clk) begin
        for (int unsigned k = 0; k < NI; k++) begin
            if (rst[k]) begin
                bcnt[k] = 0;
                presenting[k] = 0;
                continue;
            end
            if (busy[k]) bcnt[k]++;
            else if (bcnt[k] != 0) begin
                check($sformatf("busy_len[%0d]", k), bcnt[k], 8 / LN[k]);
                bcnt[k] = 0;
            end
            if (out_valid[k]) begin
                if (!presenting[k]) begin
                    int idx;
                    idx = find_entry(k);
                    if (idx < 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out[%0d]: got %h, expected no output", k, out_data[k]);
                        cur_exp[k] = out_data[k];
                    end else begin
                        exp_t e;
                        e = sb[idx];
                        sb.delete(idx);
                        check($sformatf("latency[%0d]", k), cyc - e.acc, 8 / LN[k]);
                        check($sformatf("data[%0d]", k), out_data[k], e.data);
                        cur_exp[k] = e.data;
                    end
                    presenting[k] = 1;
                end else begin
                    check($sformatf("hold_data[%0d]", k), out_data[k], cur_exp[k]);
                end
                if (out_ready[k]) presenting[k] = 0;
            end else begin
                check($sformatf("idle_zero[%0d]", k), out_data[k], 32'h0);
            end
        end
    end

    // Random backpressure on out_ready for instances that enable it.
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) if (rand_rdy[k]) out_ready[k] = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int k, input logic [47:0] d, input logic [31:0] e);
        int unsigned waitc;
        bit ok;
        waitc = 0;
        ok = 0;
        in_valid[k] = 1'b1;
        in_data[k] = d;
        while (!ok && waitc < 200) begin
            @(negedge clk);
            if (in_ready[k]) ok = 1;
            else begin
                waitc++;
                @(posedge clk);
                #1;
            end
        end
        if (ok) sb.push_back(exp_t'{inst: k, data: e, acc: cyc + 1});
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout[%0d]: got in_ready=0 for 200 cycles, expected 1", k);
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int unsigned waitc;
        waitc = 0;
        while ((find_entry(k) >= 0 || out_valid[k]) && waitc < 300) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (waitc >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout[%0d]: got pending results, expected none", k);
        end
    endtask

    initial begin
        logic [47:0] d;
        int unsigned waitc;
        rst = '1;
        in_valid = '0;
        out_ready = '1;
        for (int k = 0; k < NI; k++) begin
            in_data[k] = '0;
            rand_rdy[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = '0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_in_ready[%0d]", k), 32'(in_ready[k]), 1);
            check($sformatf("rst_out_valid[%0d]", k), 32'(out_valid[k]), 0);
            check($sformatf("rst_out_data[%0d]", k), out_data[k], 0);
            check($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
        end
        @(posedge clk);
        #1;

        // Known answers.
        send(0, 48'h0, 32'hEFA72C4D);
        send(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
        drain(0);
        send(1, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
        drain(1);
        send(2, 48'h0, 32'hD8D8DBBC);
        drain(2);

        // S5 sweep, other chunks zero.
        for (int v = 0; v < 64; v++) begin
            d = 48'(v) << 18;
            if (v == 0)       send(0, d, 32'hEFA72C4D);
            else if (v == 1)  send(0, d, 32'hEFA7EC4D);
            else if (v == 63) send(0, d, 32'hEFA73C4D);
            else              send(0, d, ref_f(d, 0));
        end
        drain(0);

        // Backpressure then back-to-back accept on LANES=4.
        out_ready[3] = 1'b0;
        d = 48'h0123_4567_89AB;
        send(3, d, ref_f(d, AP[3]));
        waitc = 0;
        while (!out_valid[3] && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check("bp_out_valid_seen", 32'(out_valid[3]), 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready[3]), 0);
            check("bp_out_valid", 32'(out_valid[3]), 1);
            @(posedge clk);
            #1;
        end
        d = 48'hFEDC_BA98_7654;
        out_ready[3] = 1'b1;
        in_valid[3] = 1'b1;
        in_data[3] = d;
        @(negedge clk);
        check("b2b_in_ready", 32'(in_ready[3]), 1);
        if (in_ready[3]) sb.push_back(exp_t'{inst: 3, data: ref_f(d, AP[3]), acc: cyc + 1});
        @(posedge clk);
        #1;
        in_valid[3] = 1'b0;
        drain(3);

        // Reset during BUSY on LANES=1; the aborted block must never appear.
        d = 48'hA5A5_5A5A_C3C3;
        send(1, d, ref_f(d, 0));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst[1] = 1'b1;
        begin
            int idx;
            idx = find_entry(1);
            if (idx >= 0) sb.delete(idx);
        end
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid[1]), 0);
        check("abort_in_ready", 32'(in_ready[1]), 1);
        check("abort_busy", 32'(busy[1]), 0);
        repeat (12) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        for (int k = 0; k < NI; k++) begin
            rand_rdy[k] = 1;
            for (int i = 0; i < 24; i++) begin
                d = {16'($urandom), 32'($urandom)};
                send(k, d, ref_f(d, AP[k]));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            rand_rdy[k] = 0;
            @(posedge clk);
            #1;
            out_ready[k] = 1'b1;
            drain(k);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
